// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage and IF/ID register.
package fetch_stage_pkg;

  localparam int unsigned XLEN = 16;
  localparam int unsigned OPW  = 5;
  localparam int unsigned STW  = 2;

  localparam logic [OPW-1:0]  OP_HALT   = 5'b00000;
  localparam logic [OPW-1:0]  OP_NOP    = 5'b00001;
  localparam logic [XLEN-1:0] NOP_INSTR = {OP_NOP, 11'h000};

  // Fetch FSM encoding
  localparam logic [STW-1:0] RUN    = 2'd0;
  localparam logic [STW-1:0] WAIT   = 2'd1;
  localparam logic [STW-1:0] HALTED = 2'd2;

  // IF/ID payload; also used for the one-entry skid buffer
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc_2;
    logic            halt;
  } if_id_t;

  function automatic logic is_halt(input logic [XLEN-1:0] word);
    return word[XLEN-1 -: OPW] == OP_HALT;
  endfunction

endpackage

// File: rtl/cla16.sv
// 16-bit carry-lookahead adder: 4-bit groups with a lookahead group-carry level.
module cla16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum
);

  logic [15:0] g;
  logic [15:0] p;
  logic [15:0] c;
  logic [3:0]  gg;
  logic [3:0]  gp;
  logic [3:0]  gc;

  // Bit and group generate/propagate, then lookahead carries
  always_comb begin
    g = a & b;
    p = a ^ b;
    for (int k = 0; k < 4; k++) begin
      gg[k] = g[4*k+3]
            | (p[4*k+3] & g[4*k+2])
            | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      gp[k] = &p[4*k +: 4];
    end
    gc[0] = cin;
    gc[1] = gg[0] | (gp[0] & cin);
    gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin);
    gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
          | (gp[2] & gp[1] & gp[0] & cin);
    for (int k = 0; k < 4; k++) begin
      c[4*k]   = gc[k];
      c[4*k+1] = g[4*k] | (p[4*k] & gc[k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & gc[k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
    end
    sum = p ^ c;
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch + IF/ID register with ready handshake, skid buffer and
// deferred redirect. Optional FETCH_ALIGN_CHECK_EN: odd PC halts with sticky err.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        branch_taken,
  input  logic [15:0] branch_PC,
  input  logic        IF_flush,
  input  logic        IF_ID_nowrite,
  output logic [15:0] imem_addr,
  output logic        imem_req,
  input  logic [15:0] imem_data,
  input  logic        imem_rdy,
  output logic [15:0] instr,
  output logic [15:0] IF_ID_PC_2,
  output logic        IF_ID_HALT,
  output logic        err
);

  logic [STW-1:0]  state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pc_plus2;
  if_id_t          if_id_q, if_id_d;
  if_id_t          skid_q, skid_d;
  logic            skid_valid_q, skid_valid_d;
  logic            redir_valid_q, redir_valid_d;
  logic [XLEN-1:0] redir_pc_q, redir_pc_d;
  logic [XLEN-1:0] target;
  if_id_t          fetched;
  if_id_t          nop_word;
  logic            redirect;
  logic            hit;
  logic            misalign;

`ifdef FETCH_ALIGN_CHECK_EN
  logic err_q, err_d;
  assign misalign = pc_q[0];
  assign err      = err_q;
`else
  assign misalign = 1'b0;
  assign err      = 1'b0;
`endif

  cla16 u_pc_add (
    .a   (pc_q),
    .b   (16'h0002),
    .cin (1'b0),
    .sum (pc_plus2)
  );

  assign redirect = branch_taken | IF_flush;
  // WAIT keeps the request up and the address stable; RUN backs off on stall,
  // redirect, misalignment or while the skid buffer still holds a word.
  assign imem_req = !rst && !skid_valid_q &&
                    ((state_q == RUN && !IF_ID_nowrite && !redirect && !misalign) ||
                     state_q == WAIT);
  assign hit       = imem_req & imem_rdy;
  assign imem_addr = pc_q;
  assign fetched   = {imem_data, pc_plus2, is_halt(imem_data)};
  assign nop_word  = {NOP_INSTR, if_id_q.pc_2, 1'b0};
  assign target    = branch_taken  ? branch_PC  :
                     redir_valid_q ? redir_pc_q : pc_q;

  assign instr      = if_id_q.instr;
  assign IF_ID_PC_2 = if_id_q.pc_2;
  assign IF_ID_HALT = if_id_q.halt;

  // Next-state: redirect/flush, then stall, then skid drain, then fetch
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    if_id_d       = if_id_q;
    skid_d        = skid_q;
    skid_valid_d  = skid_valid_q;
    redir_valid_d = redir_valid_q;
    redir_pc_d    = redir_pc_q;
`ifdef FETCH_ALIGN_CHECK_EN
    err_d         = err_q;
`endif
    if (redirect) begin
      if_id_d      = nop_word;
      skid_valid_d = 1'b0;
      if (state_q == WAIT && !hit) begin
        redir_valid_d = 1'b1;
        redir_pc_d    = target;
      end else begin
        pc_d          = target;
        redir_valid_d = 1'b0;
        state_d       = (state_q == HALTED && !branch_taken) ? HALTED : RUN;
      end
    end else if (IF_ID_nowrite) begin
      if (hit) begin
        state_d = RUN;
        if (redir_valid_q) begin
          pc_d          = redir_pc_q;
          redir_valid_d = 1'b0;
        end else begin
          skid_d       = fetched;
          skid_valid_d = 1'b1;
          pc_d         = pc_plus2;
        end
      end
    end else if (skid_valid_q) begin
      if_id_d      = skid_q;
      skid_valid_d = 1'b0;
      if (skid_q.halt) state_d = HALTED;
    end else if (hit) begin
      state_d = RUN;
      if (redir_valid_q) begin
        if_id_d       = nop_word;
        pc_d          = redir_pc_q;
        redir_valid_d = 1'b0;
      end else begin
        if_id_d = fetched;
        pc_d    = pc_plus2;
        if (fetched.halt) state_d = HALTED;
      end
    end else begin
      if_id_d = nop_word;
      if (state_q == RUN) begin
        if (misalign) begin
          state_d      = HALTED;
          if_id_d.halt = 1'b1;
`ifdef FETCH_ALIGN_CHECK_EN
          err_d        = 1'b1;
`endif
        end else begin
          state_d = WAIT;
        end
      end
    end
  end

  // State and pipeline registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= RUN;
      pc_q          <= RESET_PC;
      if_id_q       <= {NOP_INSTR, RESET_PC, 1'b0};
      skid_q        <= '0;
      skid_valid_q  <= 1'b0;
      redir_valid_q <= 1'b0;
      redir_pc_q    <= '0;
`ifdef FETCH_ALIGN_CHECK_EN
      err_q         <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      if_id_q       <= if_id_d;
      skid_q        <= skid_d;
      skid_valid_q  <= skid_valid_d;
      redir_valid_q <= redir_valid_d;
      redir_pc_q    <= redir_pc_d;
`ifdef FETCH_ALIGN_CHECK_EN
      err_q         <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: hit stream, miss, redirect in WAIT, skid
// stall, HALT, PC wrap, alignment handling and reset mid-WAIT.
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic        branch_taken;
  logic [15:0] branch_PC;
  logic        IF_flush;
  logic        IF_ID_nowrite;
  logic [15:0] imem_addr;
  logic        imem_req;
  logic [15:0] imem_data;
  logic        imem_rdy;
  logic [15:0] instr;
  logic [15:0] IF_ID_PC_2;
  logic        IF_ID_HALT;
  logic        err;

  int passed = 0;
  int total  = 0;

  fetch_stage #(.RESET_PC(16'h0000)) dut (
    .clk           (clk),
    .rst           (rst),
    .branch_taken  (branch_taken),
    .branch_PC     (branch_PC),
    .IF_flush      (IF_flush),
    .IF_ID_nowrite (IF_ID_nowrite),
    .imem_addr     (imem_addr),
    .imem_req      (imem_req),
    .imem_data     (imem_data),
    .imem_rdy      (imem_rdy),
    .instr         (instr),
    .IF_ID_PC_2    (IF_ID_PC_2),
    .IF_ID_HALT    (IF_ID_HALT),
    .err           (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic bt, input logic [15:0] bpc, input logic nw,
                       input logic rdy, input logic [15:0] data);
    branch_taken  = bt;
    branch_PC     = bpc;
    IF_flush      = 1'b0;
    IF_ID_nowrite = nw;
    imem_rdy      = rdy;
    imem_data     = data;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    step();
    total++; if (imem_req !== 1'b0) $display("FAIL rst_req: got %b want 0", imem_req); else passed++;
    total++; if (instr !== 16'h0800) $display("FAIL rst_instr: got %h want 0800", instr); else passed++;
    total++; if (IF_ID_PC_2 !== 16'h0000) $display("FAIL rst_pc2: got %h want 0000", IF_ID_PC_2); else passed++;
    total++; if (IF_ID_HALT !== 1'b0) $display("FAIL rst_halt: got %b want 0", IF_ID_HALT); else passed++;
    total++; if (err !== 1'b0) $display("FAIL rst_err: got %b want 0", err); else passed++;
    total++; if (imem_addr !== 16'h0000) $display("FAIL rst_addr: got %h want 0000", imem_addr); else passed++;
    rst = 1'b0;
    #1;
  endtask

  task automatic test_hit_stream();
    logic [15:0] exp_addr;
    for (int i = 0; i < 3; i++) begin
      exp_addr = 16'(2 * i);
      drive(1'b0, 16'h0, 1'b0, 1'b1, 16'h4000);
      total++; if (imem_addr !== exp_addr) $display("FAIL hit_addr%0d: got %h want %h", i, imem_addr, exp_addr); else passed++;
      total++; if (imem_req !== 1'b1) $display("FAIL hit_req%0d: got %b want 1", i, imem_req); else passed++;
      step();
      total++; if (instr !== 16'h4000) $display("FAIL hit_instr%0d: got %h want 4000", i, instr); else passed++;
      total++; if (IF_ID_PC_2 !== exp_addr + 16'd2) $display("FAIL hit_pc2%0d: got %h want %h", i, IF_ID_PC_2, exp_addr + 16'd2); else passed++;
    end
    drive(1'b0, 16'h0, 1'b0, 1'b1, 16'h4806);
    step();
    total++; if (IF_ID_PC_2 !== 16'h0008) $display("FAIL hit_pc2_6: got %h want 0008", IF_ID_PC_2); else passed++;
  endtask

  task automatic test_miss();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 16'h0, 1'b0, 1'b0, 16'hDEAD);
      total++; if (imem_addr !== 16'h0008) $display("FAIL miss_addr%0d: got %h want 0008", i, imem_addr); else passed++;
      total++; if (imem_req !== 1'b1) $display("FAIL miss_req%0d: got %b want 1", i, imem_req); else passed++;
      step();
      total++; if (instr !== 16'h0800) $display("FAIL miss_nop%0d: got %h want 0800", i, instr); else passed++;
    end
    total++; if (IF_ID_PC_2 !== 16'h0008) $display("FAIL miss_pc2_held: got %h want 0008", IF_ID_PC_2); else passed++;
    drive(1'b0, 16'h0, 1'b0, 1'b1, 16'h4808);
    total++; if (imem_addr !== 16'h0008) $display("FAIL miss_addr_ret: got %h want 0008", imem_addr); else passed++;
    step();
    total++; if (instr !== 16'h4808) $display("FAIL miss_instr: got %h want 4808", instr); else passed++;
    total++; if (IF_ID_PC_2 !== 16'h000A) $display("FAIL miss_pc2: got %h want 000a", IF_ID_PC_2); else passed++;
  endtask

  task automatic test_redirect_wait();
    drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    step();
    drive(1'b1, 16'h0040, 1'b0, 1'b0, 16'h0);
    total++; if (imem_addr !== 16'h000A) $display("FAIL redir_addr_stable: got %h want 000a", imem_addr); else passed++;
    total++; if (imem_req !== 1'b1) $display("FAIL redir_req_held: got %b want 1", imem_req); else passed++;
    step();
    drive(1'b0, 16'h0, 1'b0, 1'b1, 16'h4BAD);
    total++; if (imem_addr !== 16'h000A) $display("FAIL redir_addr_late: got %h want 000a", imem_addr); else passed++;
    step();
    total++; if (instr !== 16'h0800) $display("FAIL redir_discard: got %h want 0800", instr); else passed++;
    drive(1'b0, 16'h0, 1'b0, 1'b1, 16'h4840);
    total++; if (imem_addr !== 16'h0040) $display("FAIL redir_target: got %h want 0040", imem_addr); else passed++;
    step();
    total++; if (instr !== 16'h4840) $display("FAIL redir_instr: got %h want 4840", instr); else passed++;
    total++; if (IF_ID_PC_2 !== 16'h0042) $display("FAIL redir_pc2: got %h want 0042", IF_ID_PC_2); else passed++;
  endtask

  task automatic test_stall_skid();
    drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    step();
    drive(1'b0, 16'h0, 1'b1, 1'b1, 16'h4842);
    total++; if (imem_req !== 1'b1) $display("FAIL stall_wait_req: got %b want 1", imem_req); else passed++;
    step();
    total++; if (instr !== 16'h0800) $display("FAIL stall_hold1: got %h want 0800", instr); else passed++;
    total++; if (IF_ID_PC_2 !== 16'h0042) $display("FAIL stall_pc2_hold1: got %h want 0042", IF_ID_PC_2); else passed++;
    total++; if (imem_addr !== 16'h0044) $display("FAIL stall_pc_once: got %h want 0044", imem_addr); else passed++;
    drive(1'b0, 16'h0, 1'b1, 1'b1, 16'h4BAD);
    total++; if (imem_req !== 1'b0) $display("FAIL stall_req_off: got %b want 0", imem_req); else passed++;
    step();
    total++; if (instr !== 16'h0800) $display("FAIL stall_hold2: got %h want 0800", instr); else passed++;
    total++; if (imem_addr !== 16'h0044) $display("FAIL stall_no_double: got %h want 0044", imem_addr); else passed++;
    drive(1'b0, 16'h0, 1'b0, 1'b1, 16'h4BAD);
    total++; if (imem_req !== 1'b0) $display("FAIL skid_drain_req: got %b want 0", imem_req); else passed++;
    step();
    total++; if (instr !== 16'h4842) $display("FAIL skid_instr: got %h want 4842", instr); else passed++;
    total++; if (IF_ID_PC_2 !== 16'h0044) $display("FAIL skid_pc2: got %h want 0044", IF_ID_PC_2); else passed++;
    drive(1'b0, 16'h0, 1'b0, 1'b1, 16'h4844);
    total++; if (imem_addr !== 16'h0044) $display("FAIL skid_next_addr: got %h want 0044", imem_addr); else passed++;
    step();
    total++; if (instr !== 16'h4844) $display("FAIL skid_next_instr: got %h want 4844", instr); else passed++;
    drive(1'b0, 16'h0, 1'b1, 1'b1, 16'h4BAD);
    total++; if (imem_req !== 1'b0) $display("FAIL run_stall_req: got %b want 0", imem_req); else passed++;
    step();
    total++; if (instr !== 16'h4844) $display("FAIL run_stall_hold: got %h want 4844", instr); else passed++;
    total++; if (imem_addr !== 16'h0046) $display("FAIL run_stall_pc: got %h want 0046", imem_addr); else passed++;
  endtask

  task automatic test_halt();
    drive(1'b1, 16'h0006, 1'b0, 1'b0, 16'h0);
    step();
    drive(1'b0, 16'h0, 1'b0, 1'b1, 16'h0000);
    total++; if (imem_addr !== 16'h0006) $display("FAIL halt_addr: got %h want 0006", imem_addr); else passed++;
    step();
    total++; if (IF_ID_HALT !== 1'b1) $display("FAIL halt_flag: got %b want 1", IF_ID_HALT); else passed++;
    total++; if (IF_ID_PC_2 !== 16'h0008) $display("FAIL halt_pc2: got %h want 0008", IF_ID_PC_2); else passed++;
    drive(1'b0, 16'h0, 1'b0, 1'b1, 16'h4BAD);
    total++; if (imem_req !== 1'b0) $display("FAIL halted_req: got %b want 0", imem_req); else passed++;
    step();
    total++; if (instr !== 16'h0800) $display("FAIL halted_nop: got %h want 0800", instr); else passed++;
    total++; if (imem_req !== 1'b0) $display("FAIL halted_req2: got %b want 0", imem_req); else passed++;
    drive(1'b1, 16'h0020, 1'b0, 1'b0, 16'h0);
    step();
    drive(1'b0, 16'h0, 1'b0, 1'b1, 16'h4820);
    total++; if (imem_addr !== 16'h0020) $display("FAIL resume_addr: got %h want 0020", imem_addr); else passed++;
    total++; if (imem_req !== 1'b1) $display("FAIL resume_req: got %b want 1", imem_req); else passed++;
    step();
    total++; if (instr !== 16'h4820) $display("FAIL resume_instr: got %h want 4820", instr); else passed++;
  endtask

  task automatic test_wrap();
    drive(1'b1, 16'hFFFE, 1'b0, 1'b0, 16'h0);
    step();
    drive(1'b0, 16'h0, 1'b0, 1'b1, 16'h4FFE);
    total++; if (imem_addr !== 16'hFFFE) $display("FAIL wrap_addr: got %h want fffe", imem_addr); else passed++;
    step();
    total++; if (IF_ID_PC_2 !== 16'h0000) $display("FAIL wrap_pc2: got %h want 0000", IF_ID_PC_2); else passed++;
    total++; if (err !== 1'b0) $display("FAIL wrap_err: got %b want 0", err); else passed++;
    drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    total++; if (imem_addr !== 16'h0000) $display("FAIL wrap_next: got %h want 0000", imem_addr); else passed++;
  endtask

  task automatic test_align();
    drive(1'b1, 16'h0011, 1'b0, 1'b0, 16'h0);
    step();
`ifdef FETCH_ALIGN_CHECK_EN
    drive(1'b0, 16'h0, 1'b0, 1'b1, 16'h4811);
    total++; if (imem_req !== 1'b0) $display("FAIL align_req: got %b want 0", imem_req); else passed++;
    step();
    total++; if (err !== 1'b1) $display("FAIL align_err: got %b want 1", err); else passed++;
    total++; if (IF_ID_HALT !== 1'b1) $display("FAIL align_halt: got %b want 1", IF_ID_HALT); else passed++;
    total++; if (instr !== 16'h0800) $display("FAIL align_nop: got %h want 0800", instr); else passed++;
    total++; if (imem_req !== 1'b0) $display("FAIL align_req2: got %b want 0", imem_req); else passed++;
`else
    drive(1'b0, 16'h0, 1'b0, 1'b1, 16'h4811);
    total++; if (imem_addr !== 16'h0011) $display("FAIL odd_addr: got %h want 0011", imem_addr); else passed++;
    total++; if (imem_req !== 1'b1) $display("FAIL odd_req: got %b want 1", imem_req); else passed++;
    step();
    total++; if (instr !== 16'h4811) $display("FAIL odd_instr: got %h want 4811", instr); else passed++;
    total++; if (IF_ID_PC_2 !== 16'h0013) $display("FAIL odd_pc2: got %h want 0013", IF_ID_PC_2); else passed++;
    total++; if (err !== 1'b0) $display("FAIL odd_err: got %b want 0", err); else passed++;
`endif
  endtask

  task automatic test_reset_mid_wait();
    drive(1'b1, 16'h0030, 1'b0, 1'b0, 16'h0);
    step();
    drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    step();
    rst = 1'b1;
    #1;
    total++; if (imem_req !== 1'b0) $display("FAIL rstw_req: got %b want 0", imem_req); else passed++;
    total++; if (imem_addr !== 16'h0000) $display("FAIL rstw_addr: got %h want 0000", imem_addr); else passed++;
    total++; if (err !== 1'b0) $display("FAIL rstw_err: got %b want 0", err); else passed++;
    rst = 1'b0;
    drive(1'b0, 16'h0, 1'b0, 1'b1, 16'h4000);
    total++; if (imem_req !== 1'b1) $display("FAIL rstw_req_run: got %b want 1", imem_req); else passed++;
    step();
    total++; if (instr !== 16'h4000) $display("FAIL rstw_instr: got %h want 4000", instr); else passed++;
    total++; if (IF_ID_PC_2 !== 16'h0002) $display("FAIL rstw_pc2: got %h want 0002", IF_ID_PC_2); else passed++;
  endtask

  initial begin
    test_reset();
    test_hit_stream();
    test_miss();
    test_redirect_wait();
    test_stall_skid();
    test_halt();
    test_wrap();
    test_align();
    test_reset_mid_wait();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
